miner_sha_ctrl: RTL and testbench

- Sequencer for the miner SHA-256 core (msa_en / comp_en / add_en datapath).
- Runs a configurable number of back-to-back compression passes per job; default 3 = Bitcoin double-SHA of an 80-byte header (chunk 0, chunk 1 chained on the midstate, then the hash of the 32-byte digest).
- Drives the core's enables, the chunk/fh mux selects in the miner top level, and a round index for status and debug.
- Signals job completion to the nonce/compare logic.

---
 rtl/miner_sha_ctrl_if.sv | 24 ++
 rtl/miner_sha_ctrl.sv | 129 ++++++++++++
 tb/tb_miner_sha_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/miner_sha_ctrl_if.sv
// Handshake and control bundle between the miner job logic and the SHA-256 sequencer.
// The master side issues jobs; the slave side (the sequencer) drives the core controls.
interface miner_sha_ctrl_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       msa_en;
    logic       comp_en;
    logic       add_en;
    logic [1:0] pass_sel;
    logic       fh_sel;
    logic [5:0] round_idx;

    modport master (
        output start, abort,
        input  busy, done, msa_en, comp_en, add_en, pass_sel, fh_sel, round_idx
    );

    modport slave (
        input  start, abort,
        output busy, done, msa_en, comp_en, add_en, pass_sel, fh_sel, round_idx
    );
endinterface

// File: rtl/miner_sha_ctrl.sv
// Sequencer for the miner SHA-256 core: runs NUM_PASSES back-to-back compression
// passes (LOAD, SCHED, COMP, ROUNDS, ADD) per job and pulses done after the last one.
module miner_sha_ctrl #(
    parameter int NUM_PASSES   = 3,
    parameter int SCHED_CYCLES = 48,
    parameter int ROUND_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    miner_sha_ctrl_if.slave ctl
);
    typedef enum logic [2:0] {
        IDLE, LOAD, SCHED, COMP, ROUNDS, ADD, DONE
    } state_t;

    localparam logic [5:0] SCHED_FIRST = 6'(64 - SCHED_CYCLES);
    localparam logic [5:0] SCHED_LAST  = 6'd63;
    localparam logic [5:0] ROUND_LAST  = 6'(ROUND_CYCLES - 1);
    localparam logic [1:0] LAST_PASS   = 2'(NUM_PASSES - 1);

    state_t     state_reg;
    logic [5:0] count_reg;
    logic [1:0] pass_reg;
    logic       fh_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       msa_reg;
    logic       comp_reg;
    logic       add_reg;

    // Only middle passes chain on the previous h; first and last start from the IV.
    function automatic logic chain_sel(input logic [1:0] p);
        return (p != 2'd0) && (p < LAST_PASS);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= 6'd0;
            pass_reg  <= 2'd0;
            fh_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            msa_reg   <= 1'b0;
            comp_reg  <= 1'b0;
            add_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            msa_reg  <= 1'b0;
            comp_reg <= 1'b0;
            add_reg  <= 1'b0;
            if (ctl.abort && state_reg != IDLE) begin
                state_reg <= IDLE;
                count_reg <= 6'd0;
                pass_reg  <= 2'd0;
                fh_reg    <= 1'b0;
                busy_reg  <= 1'b0;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        if (ctl.start && !ctl.abort) begin
                            state_reg <= LOAD;
                            pass_reg  <= 2'd0;
                            fh_reg    <= chain_sel(2'd0);
                            busy_reg  <= 1'b1;
                            msa_reg   <= 1'b1;
                        end
                    end
                    LOAD: begin
                        state_reg <= SCHED;
                        count_reg <= SCHED_FIRST;
                    end
                    SCHED: begin
                        if (count_reg == SCHED_LAST) begin
                            state_reg <= COMP;
                            count_reg <= 6'd0;
                            comp_reg  <= 1'b1;
                        end else begin
                            count_reg <= count_reg + 6'd1;
                        end
                    end
                    COMP: begin
                        state_reg <= ROUNDS;
                        count_reg <= 6'd0;
                    end
                    ROUNDS: begin
                        if (count_reg == ROUND_LAST) begin
                            state_reg <= ADD;
                            count_reg <= 6'd0;
                            add_reg   <= 1'b1;
                        end else begin
                            count_reg <= count_reg + 6'd1;
                        end
                    end
                    ADD: begin
                        if (pass_reg < LAST_PASS) begin
                            state_reg <= LOAD;
                            pass_reg  <= pass_reg + 2'd1;
                            fh_reg    <= chain_sel(pass_reg + 2'd1);
                            msa_reg   <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                    DONE: begin
                        // pass_sel is left at the final pass until the next job starts.
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        count_reg <= 6'd0;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctl.busy      = busy_reg;
    assign ctl.done      = done_reg;
    assign ctl.msa_en    = msa_reg;
    assign ctl.comp_en   = comp_reg;
    assign ctl.add_en    = add_reg;
    assign ctl.pass_sel  = pass_reg;
    assign ctl.fh_sel    = fh_reg;
    assign ctl.round_idx = count_reg;
endmodule

// File: tb/tb_miner_sha_ctrl.sv
// Directed bench for miner_sha_ctrl: default 3-pass instance and a 1-pass instance.
module tb_miner_sha_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    miner_sha_ctrl_if if3 ();
    miner_sha_ctrl_if if1 ();

    miner_sha_ctrl #(.NUM_PASSES(3)) dut3 (.clk(clk), .rst(rst), .ctl(if3.slave));
    miner_sha_ctrl #(.NUM_PASSES(1)) dut1 (.clk(clk), .rst(rst), .ctl(if1.slave));

    int checks = 0;
    int errors = 0;

    // Snapshot layout: {busy, done, msa, comp, add, pass[1:0], fh, round_idx[5:0]}
    typedef struct {
        int          k;
        logic [13:0] v;
    } vec_t;

    logic [13:0] snap [0:399];
    vec_t        job_tab [0:16];
    vec_t        one_tab [0:5];

    function automatic logic [13:0] ex(input logic b, input logic d, input logic m,
                                       input logic c, input logic a, input logic [1:0] p,
                                       input logic f, input logic [5:0] r);
        return {b, d, m, c, a, p, f, r};
    endfunction

    function automatic logic [13:0] sample(input int which);
        if (which == 3)
            return {if3.busy, if3.done, if3.msa_en, if3.comp_en, if3.add_en,
                    if3.pass_sel, if3.fh_sel, if3.round_idx};
        return {if1.busy, if1.done, if1.msa_en, if1.comp_en, if1.add_en,
                if1.pass_sel, if1.fh_sel, if1.round_idx};
    endfunction

    task automatic set_in(input int which, input logic s, input logic a);
        if (which == 3) begin
            if3.start = s; if3.abort = a;
        end else begin
            if1.start = s; if1.abort = a;
        end
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s k=%0d got %h want %h", name, k, got, want);
        end
    endtask

    // Start a job, then record n cycles; k=0 is the LOAD cycle of pass 0.
    task automatic capture(input int which, input int n, input int abort_at,
                           input int pulse_at, input int hold_from);
        set_in(which, 1'b1, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            snap[k] = sample(which);
            set_in(which, (k == pulse_at) || (hold_from >= 0 && k >= hold_from), k == abort_at);
            @(posedge clk); #1;
        end
        set_in(which, 1'b0, 1'b0);
    endtask

    task automatic count_window(input int lo, input int hi, output int nm, output int nc,
                                output int na, output int nd, output int nf, output int nov);
        nm = 0; nc = 0; na = 0; nd = 0; nf = 0; nov = 0;
        for (int k = lo; k <= hi; k++) begin
            nm += int'(snap[k][11]);
            nc += int'(snap[k][10]);
            na += int'(snap[k][9]);
            nd += int'(snap[k][12]);
            nf += int'(snap[k][6]);
            if (int'(snap[k][11]) + int'(snap[k][10]) + int'(snap[k][9]) > 1) nov++;
        end
    endtask

    initial begin
        int nm, nc, na, nd, nf, nov;
        bit seen_comp;
        bit hit;

        job_tab[0]  = '{0,   ex(1,0,1,0,0,2'd0,0,6'd0)};
        job_tab[1]  = '{1,   ex(1,0,0,0,0,2'd0,0,6'd16)};
        job_tab[2]  = '{48,  ex(1,0,0,0,0,2'd0,0,6'd63)};
        job_tab[3]  = '{49,  ex(1,0,0,1,0,2'd0,0,6'd0)};
        job_tab[4]  = '{50,  ex(1,0,0,0,0,2'd0,0,6'd0)};
        job_tab[5]  = '{113, ex(1,0,0,0,0,2'd0,0,6'd63)};
        job_tab[6]  = '{114, ex(1,0,0,0,1,2'd0,0,6'd0)};
        job_tab[7]  = '{115, ex(1,0,1,0,0,2'd1,1,6'd0)};
        job_tab[8]  = '{116, ex(1,0,0,0,0,2'd1,1,6'd16)};
        job_tab[9]  = '{164, ex(1,0,0,1,0,2'd1,1,6'd0)};
        job_tab[10] = '{229, ex(1,0,0,0,1,2'd1,1,6'd0)};
        job_tab[11] = '{230, ex(1,0,1,0,0,2'd2,0,6'd0)};
        job_tab[12] = '{279, ex(1,0,0,1,0,2'd2,0,6'd0)};
        job_tab[13] = '{344, ex(1,0,0,0,1,2'd2,0,6'd0)};
        job_tab[14] = '{345, ex(1,1,0,0,0,2'd2,0,6'd0)};
        job_tab[15] = '{346, ex(0,0,0,0,0,2'd2,0,6'd0)};
        job_tab[16] = '{347, ex(0,0,0,0,0,2'd2,0,6'd0)};

        one_tab[0] = '{0,   ex(1,0,1,0,0,2'd0,0,6'd0)};
        one_tab[1] = '{1,   ex(1,0,0,0,0,2'd0,0,6'd16)};
        one_tab[2] = '{49,  ex(1,0,0,1,0,2'd0,0,6'd0)};
        one_tab[3] = '{114, ex(1,0,0,0,1,2'd0,0,6'd0)};
        one_tab[4] = '{115, ex(1,1,0,0,0,2'd0,0,6'd0)};
        one_tab[5] = '{116, ex(0,0,0,0,0,2'd0,0,6'd0)};

        if3.start = 1'b0; if3.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut3", 0, 32'(sample(3)), 32'd0);
        chk("reset_dut1", 0, 32'(sample(1)), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // start and abort together in IDLE: abort wins
        set_in(3, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        set_in(3, 1'b0, 1'b0);
        chk("start_abort_idle", 0, 32'(sample(3)), 32'd0);
        @(posedge clk); #1;

        // Default job with a start re-pulse at L+200 that must be ignored
        capture(3, 348, -1, 200, -1);
        for (int i = 0; i < 17; i++) begin
            chk("job3", job_tab[i].k, 32'(snap[job_tab[i].k]), 32'(job_tab[i].v));
            $display("job3 k=%0d snap=%h", job_tab[i].k, snap[job_tab[i].k]);
        end
        count_window(0, 347, nm, nc, na, nd, nf, nov);
        chk("job3_msa_count", 0, 32'(nm), 32'd3);
        chk("job3_comp_count", 0, 32'(nc), 32'd3);
        chk("job3_add_count", 0, 32'(na), 32'd3);
        chk("job3_done_count", 0, 32'(nd), 32'd1);
        chk("job3_fh_cycles", 0, 32'(nf), 32'd115);
        chk("job3_enable_overlap", 0, 32'(nov), 32'd0);

        // Abort at L+100: idle at L+101, nothing further
        capture(3, 200, 100, -1, -1);
        chk("abort_k100_rounds", 100, 32'(snap[100]), 32'(ex(1,0,0,0,0,2'd0,0,6'd50)));
        chk("abort_k101_idle", 101, 32'(snap[101]), 32'd0);
        count_window(101, 199, nm, nc, na, nd, nf, nov);
        chk("abort_no_enables", 101, 32'(nm + nc + na), 32'd0);
        chk("abort_no_done", 101, 32'(nd), 32'd0);
        $display("abort k101 snap=%h", snap[101]);

        // Clean job after abort; start held high through DONE restarts only via IDLE
        capture(3, 349, -1, -1, 340);
        chk("post_abort_load", 0, 32'(snap[0]), 32'(ex(1,0,1,0,0,2'd0,0,6'd0)));
        chk("post_abort_pass1", 115, 32'(snap[115]), 32'(ex(1,0,1,0,0,2'd1,1,6'd0)));
        chk("hold_done", 345, 32'(snap[345]), 32'(ex(1,1,0,0,0,2'd2,0,6'd0)));
        chk("hold_idle_gap", 346, 32'(snap[346]), 32'(ex(0,0,0,0,0,2'd2,0,6'd0)));
        chk("hold_restart", 347, 32'(snap[347]), 32'(ex(1,0,1,0,0,2'd0,0,6'd0)));
        $display("hold restart k347 snap=%h", snap[347]);

        // Async reset mid-ROUNDS at round_idx 30
        seen_comp = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (if3.comp_en) seen_comp = 1'b1;
            if (seen_comp && !if3.comp_en && if3.round_idx == 6'd30) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("reach_rounds_30", 0, 32'(hit), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", 0, 32'(sample(3)), 32'd0);
        $display("async reset snap=%h", sample(3));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_reset", 0, 32'(sample(3)), 32'd0);

        // Single-pass instance
        capture(1, 120, -1, -1, -1);
        for (int i = 0; i < 6; i++) begin
            chk("job1", one_tab[i].k, 32'(snap[one_tab[i].k]), 32'(one_tab[i].v));
            $display("job1 k=%0d snap=%h", one_tab[i].k, snap[one_tab[i].k]);
        end
        count_window(0, 119, nm, nc, na, nd, nf, nov);
        chk("job1_fh_cycles", 0, 32'(nf), 32'd0);
        chk("job1_done_count", 0, 32'(nd), 32'd1);
        chk("job1_msa_count", 0, 32'(nm), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
